obstacle_engine: RTL and testbench
==================================

Name: obstacle_engine

Overview:
Parametrised successor to the fixed two-obstacle logic in the game datapath. Manages NUM_OBS obstacle slots with pseudo-random spawn spacing and heights, a selectable scroll speed, sticky dino/obstacle collision detection, and a one-cycle "obstacle passed" pulse for the score counter. Sits between the frame-rate divider and GamePixelRenderer/GameScoreCounter; driven by the GameControl state.

Parameters:
NUM_OBS, 4, number of obstacle slots (2..8)
SCREEN_W, 160, spawn X coordinate
OBS_W, 4, obstacle width in pixels
MIN_H, 4, minimum obstacle height
MAX_H, 12, maximum obstacle height (MIN_H <= MAX_H <= 15+MIN_H)
MIN_GAP, 40, minimum scrolled pixels between spawns (must be >= 8)
GROUND_TOP, 100, ground Y; obstacle top = GROUND_TOP - h
DINO_LEFT, 10, dino left X (inclusive)
DINO_RIGHT, 18, dino right X (exclusive)
DINO_H, 10, dino height
LFSR_SEED, 16'hACE1, LFSR reset value (0 is forced to 1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
frame_tick  in  1  one-cycle pulse per game frame
run  in  1  high when gameState == GAME_RUNNING
clear  in  1  reinitialise game (GAME_MENU); LFSR keeps running
speed  in  2  scroll step = speed+1 pixels per frame
dino_y  in  8  dino top Y
obs_x  out  8*NUM_OBS  slot i X at bits [8i+7:8i]
obs_h  out  8*NUM_OBS  slot i height, same packing
obs_valid  out  NUM_OBS  slot active
collision  out  1  sticky collision flag
passed  out  1  one-cycle pulse when an obstacle leaves the screen

Behaviour:
- Reset (and clear): obs_x=0, obs_h=0, obs_valid=0, collision=0, passed=0, gap=0, threshold=MIN_GAP. Reset also loads LFSR with LFSR_SEED; clear does not touch LFSR.
- reset has priority over clear; clear has priority over frame_tick.
- LFSR: 16-bit Galois, taps 16,14,13,11; advances every clk cycle regardless of run.
- Work occurs only in cycles with frame_tick && run && !collision; otherwise all state holds (passed=0). Outputs are registered; results visible the cycle after frame_tick.
- Per active tick, in order, using pre-tick register values:
  1. Collision: any slot with valid && x < DINO_RIGHT && x+OBS_W > DINO_LEFT && (GROUND_TOP - h) < dino_y + DINO_H (9-bit compares, no wrap). If hit: collision<=1, no move, no spawn, passed=0 this tick.
  2. Move: step=speed+1. Each valid slot: if x < step then valid<=0 (x held), else x<=x-step.
  3. passed=1 iff at least one slot deactivated this tick (MIN_GAP >= 8 guarantees at most one).
  4. Gap: gap_next = min(gap+step, 255). If gap_next >= threshold and a free slot exists (free = not valid pre-tick), spawn into lowest-index free slot: x<=SCREEN_W, h<=min(MIN_H+lfsr[3:0], MAX_H), valid<=1, gap<=0, threshold<=MIN_GAP+lfsr[7:4]. Else gap<=gap_next.
- Slot deactivated in step 2 is not reused until the next tick.
- No free slot: spawn deferred, gap keeps accumulating (saturates at 255).
- Newly spawned obstacle is not moved in its spawn tick.
- collision clears only on reset or clear; speed changes take effect on the next tick.
- First spawn after reset/clear occurs on the tick where accumulated gap >= MIN_GAP.

Test Plan:
- Reset: assert reset 2 cycles -> obs_valid=0, collision=0, passed=0, all obs_x/obs_h=0; LFSR equals 16'hACE1 the cycle after release.
- Spawn/move: run=1, speed=0, dino_y=50, 40 frame_ticks -> slot0 valid, obs_x[7:0]=160, MIN_H<=h<=MAX_H; next tick obs_x=159; speed=3 next tick -> 155.
- Collision freeze: dino_y=90, obstacle h=12 reaches x=17 -> collision=1 on that tick's output; further 20 ticks leave obs_x unchanged; clear -> all zero, collision=0.
- Passed pulse: obstacle at x=2, speed=3 -> valid drops, passed high exactly 1 cycle, no collision with dino_y=0.
- Full slots: NUM_OBS=2, MIN_GAP=8, speed=3, tall dino_y=0 -> third spawn deferred until a slot frees; gap reads >= threshold, spawn into slot freed one tick later.
- Gating: run=0 or no frame_tick for 100 cycles -> positions/gap unchanged, passed=0; reset asserted mid-spawn tick -> reset values win.

Source files
------------

// File: rtl/obstacle_engine_if.sv
// Control inputs and obstacle/collision outputs of obstacle_engine, bundled for the
// game datapath; the engine connects through the slave modport.
interface obstacle_engine_if #(
    parameter int NUM_OBS = 4
) ();
    logic                   frame_tick;
    logic                   run;
    logic                   clear;
    logic [1:0]             speed;
    logic [7:0]             dino_y;
    logic [8*NUM_OBS-1:0]   obs_x;
    logic [8*NUM_OBS-1:0]   obs_h;
    logic [NUM_OBS-1:0]     obs_valid;
    logic                   collision;
    logic                   passed;

    modport master (
        output frame_tick, run, clear, speed, dino_y,
        input  obs_x, obs_h, obs_valid, collision, passed
    );

    modport slave (
        input  frame_tick, run, clear, speed, dino_y,
        output obs_x, obs_h, obs_valid, collision, passed
    );
endinterface

// File: rtl/obstacle_engine.sv
// NUM_OBS-slot obstacle manager: LFSR-spaced spawns, per-frame scrolling, sticky
// dino collision and a one-cycle pulse when an obstacle scrolls off the left edge.
module obstacle_engine #(
    parameter int          NUM_OBS    = 4,
    parameter int          SCREEN_W   = 160,
    parameter int          OBS_W      = 4,
    parameter int          MIN_H      = 4,
    parameter int          MAX_H      = 12,
    parameter int          MIN_GAP    = 40,
    parameter int          GROUND_TOP = 100,
    parameter int          DINO_LEFT  = 10,
    parameter int          DINO_RIGHT = 18,
    parameter int          DINO_H     = 10,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    obstacle_engine_if.slave bus
);
    localparam int          IDX_W = (NUM_OBS > 1) ? $clog2(NUM_OBS) : 1;
    localparam logic [15:0] SEED  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] TAPS  = 16'hB400;

    logic [NUM_OBS-1:0][7:0] r_x;
    logic [NUM_OBS-1:0][7:0] r_h;
    logic [NUM_OBS-1:0]      r_valid;
    logic                    r_collision;
    logic                    r_passed;
    logic [7:0]              r_gap;
    logic [7:0]              r_thresh;
    logic [15:0]             r_lfsr;

    logic [NUM_OBS-1:0][7:0] w_x;
    logic [NUM_OBS-1:0][7:0] w_h;
    logic [NUM_OBS-1:0]      w_valid;
    logic                    w_collision;
    logic                    w_passed;
    logic [7:0]              w_gap;
    logic [7:0]              w_thresh;
    logic [15:0]             w_lfsr;

    logic                    w_active;
    logic                    w_hit;
    logic                    w_have_free;
    logic                    w_spawn;
    logic [IDX_W-1:0]        w_free_idx;
    logic [7:0]              w_step;
    logic [8:0]              w_gap_sum;
    logic [7:0]              w_gap_sat;
    logic [7:0]              w_h_raw;
    logic [7:0]              w_spawn_h;
    logic [7:0]              w_spawn_thresh;

    assign w_active       = bus.frame_tick && bus.run && !r_collision;
    assign w_step         = {6'b0, bus.speed} + 8'd1;
    assign w_gap_sum      = {1'b0, r_gap} + {1'b0, w_step};
    assign w_gap_sat      = w_gap_sum[8] ? 8'hFF : w_gap_sum[7:0];
    assign w_h_raw        = 8'(MIN_H) + {4'b0, r_lfsr[3:0]};
    assign w_spawn_h      = (w_h_raw > 8'(MAX_H)) ? 8'(MAX_H) : w_h_raw;
    assign w_spawn_thresh = 8'(MIN_GAP) + {4'b0, r_lfsr[7:4]};
    assign w_spawn        = w_have_free && (w_gap_sat >= r_thresh);
    assign w_lfsr         = r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS) : (r_lfsr >> 1);

    // Overlap tests run in 9 bits so x+OBS_W and dino_y+DINO_H cannot wrap.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
        w_hit       = 1'b0;
        w_have_free = 1'b0;
        w_free_idx  = '0;
        for (int i = 0; i < NUM_OBS; i++) begin
            if (r_valid[i]
                && ({1'b0, r_x[i]} < 9'(DINO_RIGHT))
                && ({1'b0, r_x[i]} + 9'(OBS_W) > 9'(DINO_LEFT))
                && (9'(GROUND_TOP) - {1'b0, r_h[i]} < {1'b0, bus.dino_y} + 9'(DINO_H)))
                w_hit = 1'b1;
            if (!r_valid[i] && !w_have_free) begin
                w_have_free = 1'b1;
                w_free_idx  = IDX_W'(i);
            end
        end
    end

    // Free slots come from pre-tick valid, so a slot emptied this tick is reused next tick at the earliest.
    always_comb begin
        w_x         = r_x;
        w_h         = r_h;
        w_valid     = r_valid;
        w_collision = r_collision;
        w_passed    = 1'b0;
        w_gap       = r_gap;
        w_thresh    = r_thresh;
        if (bus.clear) begin
            w_x         = '0;
            w_h         = '0;
            w_valid     = '0;
            w_collision = 1'b0;
            w_gap       = '0;
            w_thresh    = 8'(MIN_GAP);
        end else if (w_active) begin
            if (w_hit) begin
                w_collision = 1'b1;
            end else begin
                for (int i = 0; i < NUM_OBS; i++) begin
                    if (r_valid[i]) begin
                        if (r_x[i] < w_step) begin
                            w_valid[i] = 1'b0;
                            w_passed   = 1'b1;
                        end else begin
                            w_x[i] = r_x[i] - w_step;
                        end
                    end
                end
                if (w_spawn) begin
                    w_x[w_free_idx]     = 8'(SCREEN_W);
                    w_h[w_free_idx]     = w_spawn_h;
                    w_valid[w_free_idx] = 1'b1;
                    w_gap               = '0;
                    w_thresh            = w_spawn_thresh;
                end else begin
                    w_gap = w_gap_sat;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the slot arrays are a handful of flops, not a RAM, so they reset like any other state.
        if (reset) begin
            r_x         <= '0;
            r_h         <= '0;
            r_valid     <= '0;
            r_collision <= 1'b0;
            r_passed    <= 1'b0;
            r_gap       <= '0;
            r_thresh    <= 8'(MIN_GAP);
            r_lfsr      <= SEED;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            r_x         <= w_x;
            r_h         <= w_h;
            r_valid     <= w_valid;
            r_collision <= w_collision;
            r_passed    <= w_passed;
            r_gap       <= w_gap;
            r_thresh    <= w_thresh;
            r_lfsr      <= w_lfsr;
        end
    end

    assign bus.obs_x     = r_x;
    assign bus.obs_h     = r_h;
    assign bus.obs_valid = r_valid;
    assign bus.collision = r_collision;
    assign bus.passed    = r_passed;
endmodule

// File: tb/tb_obstacle_engine.sv
// Directed bench for obstacle_engine: a 4-slot default instance and a 2-slot MIN_GAP=8
// instance share stimulus; LFSR-dependent heights/spacing come from a small reference model.
module tb_obstacle_engine;
    localparam int SCR = 160;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       run;
    logic       clear;
    logic [1:0] speed;
    logic [7:0] dino_y;

    int n_chk  = 0;
    int n_fail = 0;

    obstacle_engine_if #(.NUM_OBS(4)) a_if ();
    obstacle_engine_if #(.NUM_OBS(2)) b_if ();

    assign a_if.frame_tick = frame_tick;
    assign a_if.run        = run;
    assign a_if.clear      = clear;
    assign a_if.speed      = speed;
    assign a_if.dino_y     = dino_y;
    assign b_if.frame_tick = frame_tick;
    assign b_if.run        = run;
    assign b_if.clear      = clear;
    assign b_if.speed      = speed;
    assign b_if.dino_y     = dino_y;

    obstacle_engine #(.NUM_OBS(4)) u_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a_if.slave)
    );

    obstacle_engine #(.NUM_OBS(2), .MIN_GAP(8)) u_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if.slave)
    );

    always #5 clk = ~clk;

    // Reference model state; index 0 = 4-slot instance, 1 = 2-slot instance.
    int m_x    [2][8];
    int m_h    [2][8];
    bit m_v    [2][8];
    int m_gap  [2];
    int m_thr  [2];
    bit m_coll [2];
    bit m_pass [2];
    int m_lfsr;

    function automatic int p_num(int d);
        return (d == 0) ? 4 : 2;
    endfunction

    function automatic int p_gap(int d);
        return (d == 0) ? 40 : 8;
    endfunction

    // Advance the model by the clock edge that is about to happen, from current inputs.
    task automatic model_step();
        int step;
        int g;
        int fi;
        bit hit;
        bit drop;
        bit nv [8];
        for (int d = 0; d < 2; d++) begin
            if (reset || clear) begin
                for (int i = 0; i < 8; i++) begin
                    m_x[d][i] = 0;
                    m_h[d][i] = 0;
                    m_v[d][i] = 1'b0;
                end
                m_gap[d]  = 0;
                m_thr[d]  = p_gap(d);
                m_coll[d] = 1'b0;
                m_pass[d] = 1'b0;
            end else if (frame_tick && run && !m_coll[d]) begin
                hit = 1'b0;
                for (int i = 0; i < p_num(d); i++)
                    if (m_v[d][i] && m_x[d][i] < 18 && m_x[d][i] + 4 > 10
                        && (100 - m_h[d][i]) < int'(dino_y) + 10)
                        hit = 1'b1;
                m_pass[d] = 1'b0;
                if (hit) begin
                    m_coll[d] = 1'b1;
                end else begin
                    step = int'(speed) + 1;
                    drop = 1'b0;
                    fi   = -1;
                    for (int i = 0; i < p_num(d); i++) begin
                        nv[i] = m_v[d][i];
                        if (!m_v[d][i] && fi < 0) fi = i;
                        if (m_v[d][i]) begin
                            if (m_x[d][i] < step) begin
                                nv[i] = 1'b0;
                                drop  = 1'b1;
                            end else begin
                                m_x[d][i] = m_x[d][i] - step;
                            end
                        end
                    end
                    m_pass[d] = drop;
                    g = m_gap[d] + step;
                    if (g > 255) g = 255;
                    if (g >= m_thr[d] && fi >= 0) begin
                        m_x[d][fi] = SCR;
                        m_h[d][fi] = (4 + (m_lfsr & 15) > 12) ? 12 : 4 + (m_lfsr & 15);
                        nv[fi]     = 1'b1;
                        m_gap[d]   = 0;
                        m_thr[d]   = p_gap(d) + ((m_lfsr >> 4) & 15);
                    end else begin
                        m_gap[d] = g;
                    end
                    for (int i = 0; i < p_num(d); i++) m_v[d][i] = nv[i];
                end
            end else begin
                m_pass[d] = 1'b0;
            end
        end
        if (reset) m_lfsr = 32'hACE1;
        else       m_lfsr = (m_lfsr & 1) ? ((m_lfsr >> 1) ^ 32'hB400) : (m_lfsr >> 1);
    endtask

    function automatic logic [63:0] exp_x(int d);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < p_num(d); i++) r[8*i +: 8] = 8'(m_x[d][i]);
        return r;
    endfunction

    function automatic logic [63:0] exp_h(int d);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < p_num(d); i++) r[8*i +: 8] = 8'(m_h[d][i]);
        return r;
    endfunction

    function automatic logic [7:0] exp_v(int d);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < p_num(d); i++) r[i] = m_v[d][i];
        return r;
    endfunction

    // One clock: model and DUT both see the inputs set at the preceding negedge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_tick();
        frame_tick = 1'b1;
        cycle();
        frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; frame_tick = 1'b1; run = 1'b1; clear = 1'b1;
        cycle();
        cycle();
        reset = 1'b0; frame_tick = 1'b0; clear = 1'b0;
        n_chk++; if (a_if.obs_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_a_valid: got %b expected 0000", a_if.obs_valid); end
        n_chk++; if (a_if.collision !== 1'b0) begin n_fail++; $display("FAIL reset_a_collision: got %b expected 0", a_if.collision); end
        n_chk++; if (a_if.passed !== 1'b0) begin n_fail++; $display("FAIL reset_a_passed: got %b expected 0", a_if.passed); end
        n_chk++; if (a_if.obs_x !== 32'h0) begin n_fail++; $display("FAIL reset_a_x: got %h expected 0", a_if.obs_x); end
        n_chk++; if (a_if.obs_h !== 32'h0) begin n_fail++; $display("FAIL reset_a_h: got %h expected 0", a_if.obs_h); end
        n_chk++; if (b_if.obs_valid !== 2'b00) begin n_fail++; $display("FAIL reset_b_valid: got %b expected 00", b_if.obs_valid); end
    endtask

    task automatic test_spawn_move();
        run = 1'b1; speed = 2'd0; dino_y = 8'd50;
        repeat (39) do_tick();
        n_chk++; if (a_if.obs_valid !== 4'b0000) begin n_fail++; $display("FAIL spawn_early: got %b expected 0000", a_if.obs_valid); end
        do_tick();
        n_chk++; if (a_if.obs_valid !== 4'b0001) begin n_fail++; $display("FAIL spawn_valid: got %b expected 0001", a_if.obs_valid); end
        n_chk++; if (a_if.obs_x[7:0] !== 8'd160) begin n_fail++; $display("FAIL spawn_x: got %0d expected 160", a_if.obs_x[7:0]); end
        n_chk++; if (a_if.obs_h[7:0] < 8'd4 || a_if.obs_h[7:0] > 8'd12) begin n_fail++; $display("FAIL spawn_h_range: got %0d expected 4..12", a_if.obs_h[7:0]); end
        n_chk++; if ({32'h0, a_if.obs_h} !== exp_h(0)) begin n_fail++; $display("FAIL spawn_h_lfsr: got %h expected %h", a_if.obs_h, exp_h(0)); end
        do_tick();
        n_chk++; if (a_if.obs_x[7:0] !== 8'd159) begin n_fail++; $display("FAIL move_step1: got %0d expected 159", a_if.obs_x[7:0]); end
        speed = 2'd3;
        do_tick();
        n_chk++; if (a_if.obs_x[7:0] !== 8'd155) begin n_fail++; $display("FAIL move_step4: got %0d expected 155", a_if.obs_x[7:0]); end
        n_chk++; if ({48'h0, b_if.obs_x} !== exp_x(1) || {56'h0, 6'h0, b_if.obs_valid} !== exp_v(1)) begin n_fail++; $display("FAIL spawn_b_state: got x=%h v=%b expected x=%h v=%b", b_if.obs_x, b_if.obs_valid, exp_x(1), exp_v(1)); end
    endtask

    task automatic test_collision();
        repeat (34) do_tick();
        speed = 2'd0;
        do_tick();
        do_tick();
        n_chk++; if (a_if.obs_x[7:0] !== 8'd17 || a_if.collision !== 1'b0) begin n_fail++; $display("FAIL coll_approach: got x=%0d c=%b expected x=17 c=0", a_if.obs_x[7:0], a_if.collision); end
        dino_y = 8'd90;
        do_tick();
        n_chk++; if (a_if.collision !== 1'b1) begin n_fail++; $display("FAIL coll_hit: got %b expected 1", a_if.collision); end
        n_chk++; if (a_if.obs_x[7:0] !== 8'd17 || a_if.passed !== 1'b0) begin n_fail++; $display("FAIL coll_nomove: got x=%0d p=%b expected x=17 p=0", a_if.obs_x[7:0], a_if.passed); end
        n_chk++; if ({32'h0, a_if.obs_x} !== exp_x(0) || {56'h0, 4'h0, a_if.obs_valid} !== exp_v(0)) begin n_fail++; $display("FAIL coll_a_state: got x=%h v=%b expected x=%h v=%b", a_if.obs_x, a_if.obs_valid, exp_x(0), exp_v(0)); end
        speed = 2'd3;
        repeat (20) do_tick();
        n_chk++; if (a_if.obs_x[7:0] !== 8'd17 || a_if.collision !== 1'b1) begin n_fail++; $display("FAIL coll_frozen: got x=%0d c=%b expected x=17 c=1", a_if.obs_x[7:0], a_if.collision); end
        n_chk++; if ({32'h0, a_if.obs_x} !== exp_x(0)) begin n_fail++; $display("FAIL coll_frozen_all: got %h expected %h", a_if.obs_x, exp_x(0)); end
        n_chk++; if (b_if.collision !== m_coll[1] || {48'h0, b_if.obs_x} !== exp_x(1)) begin n_fail++; $display("FAIL coll_b_state: got c=%b x=%h expected c=%b x=%h", b_if.collision, b_if.obs_x, m_coll[1], exp_x(1)); end
        clear = 1'b1; frame_tick = 1'b1;
        cycle();
        clear = 1'b0; frame_tick = 1'b0;
        n_chk++; if (a_if.collision !== 1'b0 || a_if.obs_valid !== 4'b0000) begin n_fail++; $display("FAIL clear_a: got c=%b v=%b expected c=0 v=0000", a_if.collision, a_if.obs_valid); end
        n_chk++; if (a_if.obs_x !== 32'h0 || a_if.obs_h !== 32'h0) begin n_fail++; $display("FAIL clear_a_xh: got x=%h h=%h expected 0", a_if.obs_x, a_if.obs_h); end
        n_chk++; if (b_if.collision !== 1'b0 || b_if.obs_valid !== 2'b00) begin n_fail++; $display("FAIL clear_b: got c=%b v=%b expected c=0 v=00", b_if.collision, b_if.obs_valid); end
    endtask

    task automatic test_passed();
        dino_y = 8'd0; speed = 2'd3;
        repeat (9) do_tick();
        n_chk++; if (a_if.obs_valid !== 4'b0000) begin n_fail++; $display("FAIL pass_prespawn: got %b expected 0000", a_if.obs_valid); end
        do_tick();
        n_chk++; if (a_if.obs_valid !== 4'b0001 || a_if.obs_x[7:0] !== 8'd160) begin n_fail++; $display("FAIL pass_spawn: got v=%b x=%0d expected v=0001 x=160", a_if.obs_valid, a_if.obs_x[7:0]); end
        speed = 2'd1;
        do_tick();
        speed = 2'd3;
        repeat (39) do_tick();
        n_chk++; if (a_if.obs_x[7:0] !== 8'd2 || a_if.passed !== 1'b0) begin n_fail++; $display("FAIL pass_at2: got x=%0d p=%b expected x=2 p=0", a_if.obs_x[7:0], a_if.passed); end
        do_tick();
        n_chk++; if (a_if.obs_valid[0] !== 1'b0 || a_if.obs_x[7:0] !== 8'd2) begin n_fail++; $display("FAIL pass_drop: got v0=%b x=%0d expected v0=0 x=2", a_if.obs_valid[0], a_if.obs_x[7:0]); end
        n_chk++; if (a_if.passed !== 1'b1 || a_if.collision !== 1'b0) begin n_fail++; $display("FAIL pass_pulse: got p=%b c=%b expected p=1 c=0", a_if.passed, a_if.collision); end
        n_chk++; if ({56'h0, 4'h0, a_if.obs_valid} !== exp_v(0) || {32'h0, a_if.obs_h} !== exp_h(0)) begin n_fail++; $display("FAIL pass_a_state: got v=%b h=%h expected v=%b h=%h", a_if.obs_valid, a_if.obs_h, exp_v(0), exp_h(0)); end
        cycle();
        n_chk++; if (a_if.passed !== 1'b0) begin n_fail++; $display("FAIL pass_one_cycle: got %b expected 0", a_if.passed); end
        n_chk++; if (b_if.passed !== m_pass[1] || {48'h0, b_if.obs_x} !== exp_x(1)) begin n_fail++; $display("FAIL pass_b_state: got p=%b x=%h expected p=%b x=%h", b_if.passed, b_if.obs_x, m_pass[1], exp_x(1)); end
    endtask

    task automatic test_full_slots();
        dino_y = 8'd0; speed = 2'd3;
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        repeat (2) do_tick();
        n_chk++; if (b_if.obs_valid !== 2'b01 || b_if.obs_x[7:0] !== 8'd160) begin n_fail++; $display("FAIL full_first: got v=%b x=%0d expected v=01 x=160", b_if.obs_valid, b_if.obs_x[7:0]); end
        repeat (18) do_tick();
        n_chk++; if (b_if.obs_valid !== 2'b11 || b_if.obs_x[7:0] !== 8'd88) begin n_fail++; $display("FAIL full_both: got v=%b x0=%0d expected v=11 x0=88", b_if.obs_valid, b_if.obs_x[7:0]); end
        repeat (22) do_tick();
        n_chk++; if (b_if.obs_valid !== 2'b11 || b_if.obs_x[7:0] !== 8'd0) begin n_fail++; $display("FAIL full_edge: got v=%b x0=%0d expected v=11 x0=0", b_if.obs_valid, b_if.obs_x[7:0]); end
        do_tick();
        n_chk++; if (b_if.obs_valid !== 2'b10 || b_if.passed !== 1'b1) begin n_fail++; $display("FAIL full_deferred: got v=%b p=%b expected v=10 p=1", b_if.obs_valid, b_if.passed); end
        do_tick();
        n_chk++; if (b_if.obs_valid !== 2'b11 || b_if.obs_x[7:0] !== 8'd160 || b_if.passed !== 1'b0) begin n_fail++; $display("FAIL full_reuse: got v=%b x0=%0d p=%b expected v=11 x0=160 p=0", b_if.obs_valid, b_if.obs_x[7:0], b_if.passed); end
        n_chk++; if ({48'h0, b_if.obs_h} !== exp_h(1) || {48'h0, b_if.obs_x} !== exp_x(1)) begin n_fail++; $display("FAIL full_b_state: got x=%h h=%h expected x=%h h=%h", b_if.obs_x, b_if.obs_h, exp_x(1), exp_h(1)); end
    endtask

    task automatic test_gating();
        run = 1'b0;
        repeat (10) do_tick();
        n_chk++; if (b_if.obs_x[7:0] !== 8'd160 || b_if.passed !== 1'b0) begin n_fail++; $display("FAIL gate_run: got x0=%0d p=%b expected x0=160 p=0", b_if.obs_x[7:0], b_if.passed); end
        run = 1'b1;
        repeat (100) cycle();
        n_chk++; if (b_if.obs_x[7:0] !== 8'd160 || b_if.passed !== 1'b0 || {32'h0, a_if.obs_x} !== exp_x(0)) begin n_fail++; $display("FAIL gate_tick: got b_x0=%0d p=%b a_x=%h expected b_x0=160 p=0 a_x=%h", b_if.obs_x[7:0], b_if.passed, a_if.obs_x, exp_x(0)); end
        do_tick();
        n_chk++; if (b_if.obs_x[7:0] !== 8'd156) begin n_fail++; $display("FAIL gate_resume: got %0d expected 156", b_if.obs_x[7:0]); end
        repeat (15) do_tick();
        n_chk++; if ({32'h0, a_if.obs_x} !== exp_x(0) || {56'h0, 4'h0, a_if.obs_valid} !== exp_v(0)) begin n_fail++; $display("FAIL gate_a_state: got x=%h v=%b expected x=%h v=%b", a_if.obs_x, a_if.obs_valid, exp_x(0), exp_v(0)); end
        n_chk++; if ({48'h0, b_if.obs_x} !== exp_x(1) || {56'h0, 6'h0, b_if.obs_valid} !== exp_v(1)) begin n_fail++; $display("FAIL gate_b_state: got x=%h v=%b expected x=%h v=%b", b_if.obs_x, b_if.obs_valid, exp_x(1), exp_v(1)); end
        reset = 1'b1; frame_tick = 1'b1; clear = 1'b1;
        cycle();
        reset = 1'b0; frame_tick = 1'b0; clear = 1'b0;
        n_chk++; if (a_if.obs_valid !== 4'b0000 || a_if.obs_x !== 32'h0 || b_if.obs_valid !== 2'b00) begin n_fail++; $display("FAIL mid_reset: got a_v=%b a_x=%h b_v=%b expected all 0", a_if.obs_valid, a_if.obs_x, b_if.obs_valid); end
        repeat (10) do_tick();
        n_chk++; if (a_if.obs_valid !== 4'b0001 || {32'h0, a_if.obs_h} !== exp_h(0)) begin n_fail++; $display("FAIL reseed_spawn: got v=%b h=%h expected v=0001 h=%h", a_if.obs_valid, a_if.obs_h, exp_h(0)); end
    endtask

    initial begin
        reset = 1'b1; frame_tick = 1'b0; run = 1'b0; clear = 1'b0;
        speed = 2'd0; dino_y = 8'd0;
        m_lfsr = 32'hACE1;
        @(negedge clk);
        test_reset();
        test_spawn_move();
        test_collision();
        test_passed();
        test_full_slots();
        test_gating();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
